seq_alu: RTL



---
 rtl/seq_alu.sv | 138 +++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// Multi-cycle execute unit: single-cycle logic/arithmetic, iterative one-bit-per-cycle shifts,
// start/busy/done handshake with registered result and zero flag.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ALUsel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_BR   = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [3:0] OP_SLT  = 4'b1101;
    localparam logic [3:0] OP_SLTU = 4'b1111;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc_p1;
    logic [SHW-1:0]   cnt_p1;
    logic [3:0]       sel_p1;

    logic             accept;
    logic             is_shift;
    logic [SHW-1:0]   shamt;
    logic             start_iter;
    logic [WIDTH-1:0] acc_step;
    logic             last_step;

    // Single-cycle datapath; shift codes land here only with shamt=0, where result is a.
    function automatic logic [WIDTH-1:0] alu_op(input logic [3:0] sel,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
        logic signed [WIDTH-1:0] xs;
        logic signed [WIDTH-1:0] ys;
        logic [WIDTH-1:0]        r;
        xs = x;
        ys = y;
        case (sel)
            OP_ADD:                 r = x + y;
            OP_SUB, OP_BR:          r = x - y;
            OP_OR:                  r = x | y;
            OP_AND:                 r = x & y;
            OP_XOR:                 r = x ^ y;
            OP_SLL, OP_SRL, OP_SRA: r = x;
            OP_SLT:                 r = {{(WIDTH-1){1'b0}}, (xs < ys)};
            OP_SLTU:                r = {{(WIDTH-1){1'b0}}, (x < y)};
            default:                r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] shift_one(input logic [3:0] sel,
                                                   input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        case (sel)
            OP_SLL:  r = {x[WIDTH-2:0], 1'b0};
            OP_SRL:  r = {1'b0, x[WIDTH-1:1]};
            OP_SRA:  r = {x[WIDTH-1], x[WIDTH-1:1]};
            default: r = x;
        endcase
        return r;
    endfunction

    assign accept     = start && (state == IDLE);
    assign shamt      = b[SHW-1:0];
    assign is_shift   = (ALUsel == OP_SLL) || (ALUsel == OP_SRL) || (ALUsel == OP_SRA);
    assign start_iter = accept && is_shift && (shamt != '0);
    assign acc_step   = shift_one(sel_p1, acc_p1);
    assign last_step  = (state == SHIFT) && (cnt_p1 == SHW'(1));
    assign busy       = (state == SHIFT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_iter) state_nxt = SHIFT;
            SHIFT:   if (last_step)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control and architecturally visible outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt_p1 <= '0;
            result <= '0;
            zero   <= 1'b1;
            done   <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            if (accept) begin
                if (start_iter) begin
                    cnt_p1 <= shamt;
                end else begin
                    result <= alu_op(ALUsel, a, b);
                    zero   <= (alu_op(ALUsel, a, b) == '0);
                    done   <= 1'b1;
                end
            end else if (state == SHIFT) begin
                cnt_p1 <= cnt_p1 - SHW'(1);
                if (last_step) begin
                    result <= acc_step;
                    zero   <= (acc_step == '0);
                    done   <= 1'b1;
                end
            end
        end
    end

    // Shift accumulator and latched opcode carry no reset; they are only read while in SHIFT.
    always_ff @(posedge clk) begin
        if (start_iter) begin
            acc_p1 <= a;
            sel_p1 <= ALUsel;
        end else if (state == SHIFT) begin
            acc_p1 <= acc_step;
        end
    end

endmodule
